ahb_slv_itf: RTL and testbench
==============================

AHB_SLV_ITF -- requirements
Module: ahb_slv_itf

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning SRAM word-address width.
REQ-002 SHALL have hclk input 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have hrst_n input 1: asynchronous, active-low reset.
REQ-004 SHALL have AHB slave inputs: hsel 1, hready 1, htrans 2, hwrite 1, hsize 3, haddr 32, hwdata 32.
REQ-005 SHALL have AHB slave outputs: hready_resp 1, hresp 2 (00 OKAY, 01 ERROR), hrdata 32.
REQ-006 SHALL have bist_en input 1: memory under BIST, so the bus must be locked out.
REQ-007 SHALL have SRAM-side outputs: sram_addr ADDR_W, sram_wdata 32, sram_wen 1 (low = write), bank0_csn 4, bank1_csn 4 (low-active, one bit per byte lane).
REQ-008 SHALL have SRAM-side inputs sram_q0..sram_q7, 8 bits each: bank0 lanes 0-3 and bank1 lanes 0-3, valid the cycle after a read chip-select.

Function
REQ-009 SHALL decode the address map as follows.
- haddr[15] selects the bank.
- haddr[14:2] gives sram_addr.
- haddr[1:0] gives the byte lane.
- haddr[31:16] is ignored.
REQ-010 SHALL accept a transfer only when hsel & hready & htrans[1] are all 1; IDLE/BUSY transfers get OKAY with zero wait and no SRAM access.
REQ-011 SHALL generate the lane mask from hsize and the low address bits:
- byte: one-hot on haddr[1:0];
- halfword: 0011 or 1100 by haddr[1];
- word: 1111.
REQ-012 SHALL drive the selected bank's csn as ~mask and the other bank's csn as 4'hF.
REQ-013 SHALL treat the following as ERROR transfers, with no SRAM access:
- hsize>2;
- halfword with haddr[0]=1;
- word with haddr[1:0]!=0;
- any accepted transfer while bist_en=1.
REQ-014 SHALL use FSM states IDLE, WR (write data phase), RD (read data phase), STALL (read deferred behind a write), ERR1, ERR2.
REQ-015 SHALL handle a write as follows.
- The address phase is registered.
- In WR, the block drives sram_addr/csn from the registered address, sram_wen=0 and sram_wdata=hwdata.
- hready_resp=1, so the write completes with zero wait.
REQ-016 SHALL handle a read accepted while the FSM is not in WR as follows.
- In the address cycle, the block drives sram_addr/csn combinationally from haddr with sram_wen=1.
- The next cycle (RD) is the data phase: hready_resp=1, hrdata valid, zero wait.
REQ-017 SHALL handle a read accepted while the FSM is in WR (port conflict) as follows.
- The read address and mask are captured into a hold register.
- The FSM enters STALL with hready_resp=0.
- In STALL, the block issues the read from the hold register.
- The FSM then enters RD; the total is exactly one wait state.
REQ-018 SHALL NOT sample a new address phase while hready_resp=0.
REQ-019 SHALL form hrdata as follows.
- In RD: {sram_q3,sram_q2,sram_q1,sram_q0} when the registered bank=0, {sram_q7..sram_q4} when bank=1.
- All lanes are returned regardless of size.
- 32'h0 in all other states.
REQ-020 SHALL give the ERROR response over two cycles: ERR1 (hready_resp=0, hresp=01), then ERR2 (hready_resp=1, hresp=01).
REQ-021 SHALL accept a transfer presented during ERR2 and process it normally.
REQ-022 SHALL treat a transfer that becomes an error while in WR as follows: the pending write completes first, and ERR1 follows in the next cycle.
REQ-023 SHALL hold bank0_csn and bank1_csn at 4'hF whenever bist_en=1, overriding any pending write or read.
REQ-024 SHALL drive, when no SRAM access is active:
- csn=4'hF on both banks;
- sram_wen=1;
- sram_addr and sram_wdata holding their last values.

Reset
REQ-025 SHALL, while hrst_n=0, force the following:
- state IDLE;
- hready_resp=1, hresp=00, hrdata=0;
- bank0_csn=bank1_csn=4'hF, sram_wen=1;
- sram_addr=0, sram_wdata=0;
- hold register cleared.
REQ-026 SHALL abandon any WR/STALL/ERR operation on reset assertion mid-operation, with no SRAM write after reset; the first accepted transfer after release behaves as from IDLE.

Verification
REQ-027 SHALL cover word write then read with a gap: write 0x0000_0010 data 0xA5A51234, IDLE cycle, read 0x10 -> write cycle shows sram_addr=4, bank0_csn=0000, sram_wen=0; read returns 0xA5A51234 with zero wait.
REQ-028 SHALL cover back-to-back write then read: write 0x20 data 0x11223344, read 0x20 immediately -> exactly one cycle hready_resp=0 (STALL), then hrdata=0x11223344.
REQ-029 SHALL cover byte write to bank1: byte write 0x77 to 0x0000_8003 -> bank1_csn=0111, bank0_csn=1111, sram_addr=0; word read 0x8000 returns 0x77 in bits 31:24.
REQ-030 SHALL cover the misaligned-halfword error: halfword at 0x0000_0001 -> ERR1 (hready_resp=0, hresp=01), then ERR2 (hready_resp=1, hresp=01); csn stays 4'hF throughout.
REQ-031 SHALL cover BIST lockout: bist_en=1, word write 0x40 -> ERROR response, both csn stay 4'hF; after bist_en=0, the same write succeeds.
REQ-032 SHALL cover reset in STALL: hrst_n=0 during STALL -> next cycle hready_resp=1, all csn=4'hF, hrdata=0; a subsequent read is zero-wait.

Source files
------------

// File: rtl/ahb_slv_itf.sv
// AHB-lite slave front end for a two-bank, byte-laned SRAM (4 lanes per bank).
// Writes take zero wait states. A read that collides with a write data phase costs one wait state.
module ahb_slv_itf #(
  parameter int ADDR_W = 13
) (
  input  logic              hclk,
  input  logic              hrst_n,
  input  logic              hsel,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       haddr,
  input  logic [31:0]       hwdata,
  output logic              hready_resp,
  output logic [1:0]        hresp,
  output logic [31:0]       hrdata,
  input  logic              bist_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_wen,
  output logic [3:0]        bank0_csn,
  output logic [3:0]        bank1_csn,
  input  logic [7:0]        sram_q0,
  input  logic [7:0]        sram_q1,
  input  logic [7:0]        sram_q2,
  input  logic [7:0]        sram_q3,
  input  logic [7:0]        sram_q4,
  input  logic [7:0]        sram_q5,
  input  logic [7:0]        sram_q6,
  input  logic [7:0]        sram_q7
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_STALL, S_ERR1, S_ERR2} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_addr, r_hold_addr, r_sram_addr, w_acc_addr;
  logic [3:0]          r_wr_mask, r_hold_mask, w_acc_mask, w_mask;
  logic                r_wr_bank, r_hold_bank, r_rd_bank, w_acc_bank;
  logic [31:0]         r_sram_wdata;
  logic                w_rdy, w_acc, w_err, w_rd_now, w_acc_vld, w_wr_act;
  logic                w_unused_bits;

  assign w_unused_bits = ^{haddr[31:16], htrans[0]};

  // Reset gates acceptance so nothing reaches the SRAM while hrst_n is low.
  assign w_rdy    = (r_state != S_STALL) && (r_state != S_ERR1);
  assign w_acc    = hrst_n & hsel & hready & htrans[1] & w_rdy;
  assign w_err    = bist_en || (hsize > 3'd2) || ((hsize == 3'd1) && haddr[0]) ||
                    ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_rd_now = w_acc & ~w_err & ~hwrite & (r_state != S_WR);
  assign w_wr_act = (r_state == S_WR) & ~bist_en;

  always_comb begin
    w_mask = 4'b1111;
    case (hsize)
      3'd0:    w_mask = 4'b0001 << haddr[1:0];
      3'd1:    w_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_STALL: w_state_nxt = S_RD;
      S_ERR1:  w_state_nxt = S_ERR2;
      default: begin
        if (!w_acc)         w_state_nxt = S_IDLE;
        else if (w_err)     w_state_nxt = S_ERR1;
        else if (hwrite)    w_state_nxt = S_WR;
        else if (r_state == S_WR) w_state_nxt = S_STALL;
        else                w_state_nxt = S_RD;
      end
    endcase
  end

  always_comb begin
    hready_resp = w_rdy;
    hresp       = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
    hrdata      = 32'h0;
    if (r_state == S_RD)
      hrdata = r_rd_bank ? {sram_q7, sram_q6, sram_q5, sram_q4}
                         : {sram_q3, sram_q2, sram_q1, sram_q0};
  end

  // SRAM port: pending write, deferred read, or a fresh read straight from the bus.
  always_comb begin
    w_acc_vld  = 1'b0;
    w_acc_addr = r_sram_addr;
    w_acc_bank = 1'b0;
    w_acc_mask = 4'b0000;
    if (r_state == S_WR) begin
      w_acc_vld  = 1'b1;
      w_acc_addr = r_wr_addr;
      w_acc_bank = r_wr_bank;
      w_acc_mask = r_wr_mask;
    end else if (r_state == S_STALL) begin
      w_acc_vld  = 1'b1;
      w_acc_addr = r_hold_addr;
      w_acc_bank = r_hold_bank;
      w_acc_mask = r_hold_mask;
    end else if (w_rd_now) begin
      w_acc_vld  = 1'b1;
      w_acc_addr = haddr[2 +: ADDR_W];
      w_acc_bank = haddr[15];
      w_acc_mask = w_mask;
    end
    if (bist_en) w_acc_vld = 1'b0;
  end

  assign sram_addr  = w_acc_vld ? w_acc_addr : r_sram_addr;
  assign sram_wdata = w_wr_act ? hwdata : r_sram_wdata;
  assign sram_wen   = ~w_wr_act;
  assign bank0_csn  = (w_acc_vld && !w_acc_bank) ? ~w_acc_mask : 4'hF;
  assign bank1_csn  = (w_acc_vld &&  w_acc_bank) ? ~w_acc_mask : 4'hF;

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_wr_addr    <= '0;
      r_wr_bank    <= 1'b0;
      r_wr_mask    <= 4'h0;
      r_hold_addr  <= '0;
      r_hold_bank  <= 1'b0;
      r_hold_mask  <= 4'h0;
      r_rd_bank    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= 32'h0;
    end else begin
      r_sram_addr  <= sram_addr;
      r_sram_wdata <= sram_wdata;
      if (w_acc && !w_err && hwrite) begin
        r_wr_addr <= haddr[2 +: ADDR_W];
        r_wr_bank <= haddr[15];
        r_wr_mask <= w_mask;
      end
      if (w_acc && !w_err && !hwrite && (r_state == S_WR)) begin
        r_hold_addr <= haddr[2 +: ADDR_W];
        r_hold_bank <= haddr[15];
        r_hold_mask <= w_mask;
      end
      if (w_rd_now)                r_rd_bank <= haddr[15];
      else if (r_state == S_STALL) r_rd_bank <= r_hold_bank;
    end
  end

endmodule

// File: tb/tb_ahb_slv_itf.sv
// Directed bench for ahb_slv_itf with a byte-laned two-bank SRAM model behind it.
module tb_ahb_slv_itf;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic        hsel, hready, hwrite, bist_en;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_wen;
  logic [3:0]  bank0_csn, bank1_csn;
  logic [7:0]  sram_q [8];
  logic [7:0]  mem [2][4][8192];

  int n_chk = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;
  assign hready = hready_resp;

  ahb_slv_itf #(.ADDR_W(13)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .hsel(hsel), .hready(hready), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata), .bist_en(bist_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wen(sram_wen),
    .bank0_csn(bank0_csn), .bank1_csn(bank1_csn),
    .sram_q0(sram_q[0]), .sram_q1(sram_q[1]), .sram_q2(sram_q[2]), .sram_q3(sram_q[3]),
    .sram_q4(sram_q[4]), .sram_q5(sram_q[5]), .sram_q6(sram_q[6]), .sram_q7(sram_q[7])
  );

  // Synchronous SRAM: write when csn low and wen low, otherwise registered read.
  always @(posedge hclk) begin
    for (int l = 0; l < 4; l++) begin
      if (!bank0_csn[l]) begin
        if (!sram_wen) mem[0][l][sram_addr] <= sram_wdata[8*l +: 8];
        else           sram_q[l] <= mem[0][l][sram_addr];
      end
      if (!bank1_csn[l]) begin
        if (!sram_wen) mem[1][l][sram_addr] <= sram_wdata[8*l +: 8];
        else           sram_q[4+l] <= mem[1][l][sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic samp();
    @(negedge hclk);
  endtask

  task automatic aph(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 4; l++)
        for (int w = 0; w < 8192; w++) mem[b][l][w] = 8'h00;
    for (int i = 0; i < 8; i++) sram_q[i] = 8'h00;
    hrst_n = 1'b0; bist_en = 1'b0; hsize = 3'd0; haddr = 32'h0; hwdata = 32'h0;
    bus_idle();

    samp();
    chk("rst_ready", 32'(hready_resp), 32'h1);
    chk("rst_hresp", 32'(hresp), 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    chk("rst_wen", 32'(sram_wen), 32'h1);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_wdata", sram_wdata, 32'h0);
    tick();
    hrst_n = 1'b1;

    // Word write, idle gap, word read
    aph(1'b1, 3'd2, 32'h0000_0010);
    samp(); chk("t1_aph_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    tick(); hwdata = 32'hA5A5_1234; bus_idle();
    samp();
    chk("t1_wr_addr", 32'(sram_addr), 32'h4);
    chk("t1_wr_csn", 32'({bank1_csn, bank0_csn}), 32'hF0);
    chk("t1_wr_wen", 32'(sram_wen), 32'h0);
    chk("t1_wr_wdata", sram_wdata, 32'hA5A5_1234);
    chk("t1_wr_ready", 32'(hready_resp), 32'h1);
    tick();
    samp();
    chk("t1_idle_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    chk("t1_idle_addr_hold", 32'(sram_addr), 32'h4);
    chk("t1_idle_hresp", 32'(hresp), 32'h0);
    tick(); aph(1'b0, 3'd2, 32'h0000_0010);
    samp();
    chk("t1_rd_csn", 32'({bank1_csn, bank0_csn}), 32'hF0);
    chk("t1_rd_wen", 32'(sram_wen), 32'h1);
    tick(); bus_idle();
    samp();
    chk("t1_rd_ready", 32'(hready_resp), 32'h1);
    chk("t1_rd_data", hrdata, 32'hA5A5_1234);

    // Back-to-back write then read of the same word
    tick(); aph(1'b1, 3'd2, 32'h0000_0020);
    tick(); hwdata = 32'h1122_3344; aph(1'b0, 3'd2, 32'h0000_0020);
    samp();
    chk("t2_wr_wen", 32'(sram_wen), 32'h0);
    chk("t2_wr_addr", 32'(sram_addr), 32'h8);
    tick(); bus_idle();
    samp();
    chk("t2_stall_ready", 32'(hready_resp), 32'h0);
    chk("t2_stall_csn", 32'({bank1_csn, bank0_csn}), 32'hF0);
    chk("t2_stall_wen", 32'(sram_wen), 32'h1);
    tick();
    samp();
    chk("t2_rd_ready", 32'(hready_resp), 32'h1);
    chk("t2_rd_data", hrdata, 32'h1122_3344);

    // Byte write to bank1 lane 3, then word read
    tick(); aph(1'b1, 3'd0, 32'h0000_8003);
    tick(); hwdata = 32'h7700_0000; bus_idle();
    samp();
    chk("t3_b1_csn", 32'(bank1_csn), 32'h7);
    chk("t3_b0_csn", 32'(bank0_csn), 32'hF);
    chk("t3_addr", 32'(sram_addr), 32'h0);
    chk("t3_wen", 32'(sram_wen), 32'h0);
    tick(); aph(1'b0, 3'd2, 32'h0000_8000);
    samp(); chk("t3_rd_csn", 32'({bank1_csn, bank0_csn}), 32'h0F);
    tick(); bus_idle();
    samp(); chk("t3_rd_data", hrdata, 32'h7700_0000);

    // Misaligned halfword
    tick(); aph(1'b0, 3'd1, 32'h0000_0001);
    samp(); chk("t4_aph_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    tick(); bus_idle();
    samp();
    chk("t4_err1_ready", 32'(hready_resp), 32'h0);
    chk("t4_err1_hresp", 32'(hresp), 32'h1);
    chk("t4_err1_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    tick();
    samp();
    chk("t4_err2_ready", 32'(hready_resp), 32'h1);
    chk("t4_err2_hresp", 32'(hresp), 32'h1);
    chk("t4_err2_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    tick();
    samp(); chk("t4_after_hresp", 32'(hresp), 32'h0);

    // BIST lockout, retry presented during ERR2
    tick(); bist_en = 1'b1; aph(1'b1, 3'd2, 32'h0000_0040);
    samp(); chk("t5_aph_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    tick(); bus_idle();
    samp();
    chk("t5_err1_hresp", 32'(hresp), 32'h1);
    chk("t5_err1_ready", 32'(hready_resp), 32'h0);
    chk("t5_err1_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    tick(); bist_en = 1'b0; aph(1'b1, 3'd2, 32'h0000_0040);
    samp();
    chk("t5_err2_ready", 32'(hready_resp), 32'h1);
    chk("t5_err2_hresp", 32'(hresp), 32'h1);
    tick(); hwdata = 32'hCAFE_F00D; bus_idle();
    samp();
    chk("t5_wr_csn", 32'({bank1_csn, bank0_csn}), 32'hF0);
    chk("t5_wr_wen", 32'(sram_wen), 32'h0);
    chk("t5_wr_addr", 32'(sram_addr), 32'h10);
    chk("t5_wr_hresp", 32'(hresp), 32'h0);

    // Reset while stalled
    tick(); aph(1'b1, 3'd2, 32'h0000_0030);
    tick(); hwdata = 32'h5555_AAAA; aph(1'b0, 3'd2, 32'h0000_0030);
    tick(); bus_idle();
    samp(); chk("t6_stall_ready", 32'(hready_resp), 32'h0);
    #2 hrst_n = 1'b0;
    samp();
    chk("t6_rst_ready", 32'(hready_resp), 32'h1);
    chk("t6_rst_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
    chk("t6_rst_hrdata", hrdata, 32'h0);
    chk("t6_rst_wen", 32'(sram_wen), 32'h1);
    chk("t6_rst_addr", 32'(sram_addr), 32'h0);
    tick(); hrst_n = 1'b1; aph(1'b0, 3'd2, 32'h0000_0010);
    samp(); chk("t6_rd_csn", 32'({bank1_csn, bank0_csn}), 32'hF0);
    tick(); bus_idle();
    samp();
    chk("t6_rd_ready", 32'(hready_resp), 32'h1);
    chk("t6_rd_data", hrdata, 32'hA5A5_1234);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
